// File: rtl/scan_mux_pkg.sv
// rtl/scan_mux_pkg.sv - shared mode/state types for the scanning channel multiplexer
package scan_mux_pkg;

    typedef enum logic {
        MODE_MAN  = 1'b0,
        MODE_SCAN = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAN  = 2'd1,
        ST_SCAN = 2'd2
    } state_e;

endpackage

// File: rtl/scan_mux_nto1.sv
// rtl/scan_mux_nto1.sv - combinational N:1 slice selector with out-of-range flag
module mux_nto1 #(
    parameter int N_CH  = 16,
    parameter int W     = 8,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic [N_CH*W-1:0] i_d,
    input  logic [SEL_W-1:0]  i_sel,
    output logic [W-1:0]      o_y,
    output logic              o_in_range
);

    always_comb begin
        o_y        = '0;
        o_in_range = (int'(i_sel) < N_CH);
        for (int k = 0; k < N_CH; k++) begin
            if (int'(i_sel) == k) begin
                o_y = i_d[k*W +: W];
            end
        end
    end

endmodule

// File: rtl/scan_mux_n.sv
// rtl/scan_mux_n.sv - registered N-channel mux with manual select and dwell-timed auto-scan
// Optional channel mask enabled by defining SCAN_MUX_MASK_EN.
module scan_mux_n
    import scan_mux_pkg::*;
#(
    parameter int N_CH    = 16,
    parameter int W       = 8,
    parameter int SEL_W   = $clog2(N_CH),
    parameter int DWELL_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH*W-1:0] d,
    input  logic [SEL_W-1:0]  sel,
    input  logic              mode,
    input  logic [DWELL_W-1:0] dwell,
    input  logic              hold,
`ifdef SCAN_MUX_MASK_EN
    input  logic [N_CH-1:0]   ch_mask,
`endif
    output logic [W-1:0]      y,
    output logic [SEL_W-1:0]  y_ch,
    output logic              y_valid,
    output logic              wrap
);

    state_e              r_state;
    state_e              w_state_nxt;
    logic [SEL_W-1:0]    r_cur;
    logic [DWELL_W-1:0]  r_cnt;
    logic                r_wrap_pend;
    logic [W-1:0]        r_y;
    logic [SEL_W-1:0]    r_y_ch;
    logic                r_y_valid;
    logic                r_wrap;

    logic                w_scan_req;
    logic [SEL_W-1:0]    w_idx;
    logic [W-1:0]        w_mux_y;
    logic                w_in_range;
    logic [SEL_W-1:0]    w_nxt_cur;
    logic                w_nxt_wrap;
    logic                w_cnt_hit;
    logic                w_any;
    logic                w_scan_valid;

    assign w_scan_req = (mode_e'(mode) == MODE_SCAN);
    assign w_idx      = (r_state == ST_SCAN) ? r_cur : sel;

    mux_nto1 #(.N_CH(N_CH), .W(W), .SEL_W(SEL_W)) u_mux (
        .i_d        (d),
        .i_sel      (w_idx),
        .o_y        (w_mux_y),
        .o_in_range (w_in_range)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: w_state_nxt = w_scan_req ? ST_SCAN : ST_MAN;
            ST_MAN:  if (w_scan_req)  w_state_nxt = ST_SCAN;
            ST_SCAN: if (!w_scan_req) w_state_nxt = ST_MAN;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

`ifdef SCAN_MUX_MASK_EN
    logic w_found;

    // Search upward from cur for the next enabled channel; crossing N_CH-1 flags a wrap.
    always_comb begin
        w_found    = 1'b0;
        w_nxt_cur  = r_cur;
        w_nxt_wrap = 1'b0;
        for (int i = 1; i <= N_CH; i++) begin
            if (!w_found && ch_mask[(int'(r_cur) + i >= N_CH) ? int'(r_cur) + i - N_CH
                                                                : int'(r_cur) + i]) begin
                w_found    = 1'b1;
                w_nxt_cur  = SEL_W'((int'(r_cur) + i >= N_CH) ? int'(r_cur) + i - N_CH
                                                              : int'(r_cur) + i);
                w_nxt_wrap = (int'(r_cur) + i >= N_CH);
            end
        end
    end

    assign w_any        = |ch_mask;
    assign w_cnt_hit    = (r_cnt == dwell) || !ch_mask[r_cur];
    assign w_scan_valid = w_any && ch_mask[r_cur];
`else
    assign w_nxt_wrap   = (r_cur == SEL_W'(N_CH - 1));
    assign w_nxt_cur    = w_nxt_wrap ? '0 : r_cur + 1'b1;
    assign w_any        = 1'b1;
    assign w_cnt_hit    = (r_cnt == dwell);
    assign w_scan_valid = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cur       <= '0;
            r_cnt       <= '0;
            r_wrap_pend <= 1'b0;
            r_y         <= '0;
            r_y_ch      <= '0;
            r_y_valid   <= 1'b0;
            r_wrap      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_MAN: begin
                    r_y         <= w_mux_y;
                    r_y_ch      <= sel;
                    r_y_valid   <= w_in_range;
                    r_wrap      <= 1'b0;
                    r_wrap_pend <= 1'b0;
                    if (w_scan_req) begin
                        r_cur <= w_in_range ? sel : '0;
                        r_cnt <= '0;
                    end
                end
                ST_SCAN: begin
                    r_y       <= w_mux_y;
                    r_y_ch    <= r_cur;
                    r_y_valid <= w_scan_valid;
                    r_wrap    <= r_wrap_pend && !hold;
                    // Mode change beats hold; hold beats a due advance.
                    if (w_scan_req && !hold) begin
                        if (w_cnt_hit && w_any) begin
                            r_cnt       <= '0;
                            r_cur       <= w_nxt_cur;
                            r_wrap_pend <= w_nxt_wrap;
                        end else begin
                            r_cnt       <= r_cnt + 1'b1;
                            r_wrap_pend <= 1'b0;
                        end
                    end else begin
                        r_wrap_pend <= 1'b0;
                    end
                end
                default: begin
                    r_y         <= '0;
                    r_y_ch      <= '0;
                    r_y_valid   <= 1'b0;
                    r_wrap      <= 1'b0;
                    r_wrap_pend <= 1'b0;
                end
            endcase
        end
    end

    assign y       = r_y;
    assign y_ch    = r_y_ch;
    assign y_valid = r_y_valid;
    assign wrap    = r_wrap;

endmodule

// File: tb/tb_scan_mux_n.sv
// tb/tb_scan_mux_n.sv - scoreboard bench for scan_mux_n with 12 channels of 8 bits
module tb_scan_mux_n;

    localparam int N_CH    = 12;
    localparam int W       = 8;
    localparam int SEL_W   = 4;
    localparam int DWELL_W = 8;

    typedef struct {
        logic             chk;
        logic [W-1:0]     y;
        logic [SEL_W-1:0] ch;
        logic             v;
        logic             wr;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [N_CH*W-1:0]   d;
    logic [SEL_W-1:0]    sel;
    logic                mode;
    logic [DWELL_W-1:0]  dwell;
    logic                hold;
`ifdef SCAN_MUX_MASK_EN
    logic [N_CH-1:0]     ch_mask;
`endif
    logic [W-1:0]        y;
    logic [SEL_W-1:0]    y_ch;
    logic                y_valid;
    logic                wrap;

    exp_t sb[$];
    exp_t m_e;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    scan_mux_n #(.N_CH(N_CH), .W(W), .DWELL_W(DWELL_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .d       (d),
        .sel     (sel),
        .mode    (mode),
        .dwell   (dwell),
        .hold    (hold),
`ifdef SCAN_MUX_MASK_EN
        .ch_mask (ch_mask),
`endif
        .y       (y),
        .y_ch    (y_ch),
        .y_valid (y_valid),
        .wrap    (wrap)
    );

    function automatic logic [W-1:0] dv(input int k);
        return 8'h10 + W'(k);
    endfunction

    // Expectation for the edge just taken is queued; inputs for the next edge follow at +1.
    task automatic tick(input logic chk, input logic [W-1:0] ey, input logic [SEL_W-1:0] ech,
                        input logic ev, input logic ew);
        exp_t e;
        @(posedge clk);
        e.chk = chk;
        e.y   = ey;
        e.ch  = ech;
        e.v   = ev;
        e.wr  = ew;
        sb.push_back(e);
        #1;
    endtask

    task automatic scan_ch(input int c, input logic ew);
        tick(1'b1, dv(c), SEL_W'(c), 1'b1, ew);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            m_e = sb.pop_front();
            if (m_e.chk) begin
                checks++;
                if (y !== m_e.y || y_ch !== m_e.ch || y_valid !== m_e.v || wrap !== m_e.wr) begin
                    failures++;
                    $display("FAIL out@%0t: got y=%h ch=%0d v=%b wrap=%b, want y=%h ch=%0d v=%b wrap=%b",
                             $time, y, y_ch, y_valid, wrap, m_e.y, m_e.ch, m_e.v, m_e.wr);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seq1 [12] = '{10, 10, 10, 11, 11, 11, 0, 0, 0, 1, 1, 1};
        for (int k = 0; k < N_CH; k++) d[k*W +: W] = dv(k);
        rst_n = 1'b0;
        mode  = 1'b0;
        sel   = 4'd5;
        dwell = '0;
        hold  = 1'b0;
`ifdef SCAN_MUX_MASK_EN
        ch_mask = '1;
`endif
        repeat (3) tick(1'b1, 8'h00, 4'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick(1'b1, 8'h00, 4'd0, 1'b0, 1'b0);
        tick(1'b1, 8'h15, 4'd5, 1'b1, 1'b0);

        sel = 4'd3;  tick(1'b1, 8'h13, 4'd3, 1'b1, 1'b0);
        sel = 4'd14; tick(1'b1, 8'h00, 4'd14, 1'b0, 1'b0);
        sel = 4'd11; tick(1'b1, 8'h1B, 4'd11, 1'b1, 1'b0);

        sel   = 4'd10;
        dwell = 8'd2;
        mode  = 1'b1;
        tick(1'b1, 8'h1A, 4'd10, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) scan_ch(seq1[i], (i == 6));

        dwell = 8'd0;
        for (int c = 2; c <= 5; c++) scan_ch(c, 1'b0);
        hold = 1'b1;
        scan_ch(6, 1'b0);
        scan_ch(6, 1'b0);
        d[6*W +: W] = 8'hA6;
        tick(1'b1, 8'hA6, 4'd6, 1'b1, 1'b0);
        tick(1'b1, 8'hA6, 4'd6, 1'b1, 1'b0);
        hold = 1'b0;
        tick(1'b1, 8'hA6, 4'd6, 1'b1, 1'b0);
        d[6*W +: W] = dv(6);
        for (int c = 7; c <= 9; c++) scan_ch(c, 1'b0);

        rst_n = 1'b0;
        tick(1'b1, 8'h00, 4'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick(1'b1, 8'h00, 4'd0, 1'b0, 1'b0);
        for (int c = 0; c < N_CH; c++) scan_ch(c, 1'b0);
        scan_ch(0, 1'b1);

`ifdef SCAN_MUX_MASK_EN
        ch_mask = 12'b0000_1000_0101;
        tick(1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
        scan_ch(2, 1'b0);
        scan_ch(7, 1'b0);
        scan_ch(0, 1'b1);
        scan_ch(2, 1'b0);
        scan_ch(7, 1'b0);
        scan_ch(0, 1'b1);
        ch_mask = '0;
        tick(1'b1, dv(2), 4'd2, 1'b0, 1'b0);
        tick(1'b1, dv(2), 4'd2, 1'b0, 1'b0);
`endif

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
